// File: rtl/disp_digit_seg_dec.sv
`default_nettype none
// ============================================================================
// Module  : disp_digit_seg_dec
// Purpose : Recovers a hex digit from a rendered 7-segment cell in a pixel
//           stream by counting dark pixels per segment window each frame,
//           thresholding the counts and mapping the segment vector to 0..F.
// Revision: 1.0 - initial release
// ============================================================================
module disp_digit_seg_dec #(
  parameter logic [6:0]  MAX_H     = 7'd64,
  parameter logic [6:0]  MAX_V     = 7'd96,
  parameter logic [6:0]  BOUNDARY  = 7'd5,
  parameter logic [6:0]  THICKNESS = 7'd5,
  parameter logic [7:0]  DARK_TH   = 8'h10,
  parameter logic [11:0] MIN_HITS  = 12'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic       i_eof,
  input  logic [6:0] cnt_h,
  input  logic [6:0] cnt_v,
  input  logic [7:0] i_red,
  input  logic [7:0] i_grn,
  input  logic [7:0] i_blu,
  output logic       o_valid,
  output logic [6:0] o_seg,
  output logic [3:0] o_digit,
  output logic       o_match,
  output logic       o_busy
);

  // Segment window geometry; mirrors the renderer's layout arithmetic.
  localparam int B      = int'(BOUNDARY);
  localparam int T      = int'(THICKNESS);
  localparam int W      = int'(MAX_H);
  localparam int HEIGHT = (int'(MAX_V) - 2 * B - 3 * T) / 2;

  localparam int H_LO  = B + T;
  localparam int H_HI  = W - B - T;
  localparam int L_LO  = B;
  localparam int L_HI  = B + T;
  localparam int R_LO  = W - B - T;
  localparam int R_HI  = W - B;
  localparam int V0_LO = B;
  localparam int V0_HI = B + T;
  localparam int V1_HI = B + T + HEIGHT;
  localparam int V3_HI = B + 2 * T + HEIGHT;
  localparam int V4_HI = B + 2 * T + 2 * HEIGHT;
  localparam int V6_HI = B + 3 * T + 2 * HEIGHT;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [11:0] cnt      [7];
  logic [11:0] cnt_next [7];
  logic [6:0]  hit;
  logic [6:0]  seg_hit;
  logic [6:0]  seg_r;
  logic        seg_v;
  logic        dark;
  logic        restart;
  logic        count_en;
  logic        close;
  logic        in_h, in_l, in_r;
  logic        in_v0, in_v12, in_v3, in_v45, in_v6;
  logic [3:0]  dec_digit;
  logic        dec_match;
  int          h_pos;
  int          v_pos;

  assign h_pos   = int'(cnt_h);
  assign v_pos   = int'(cnt_v);
  assign dark    = (i_red < DARK_TH) && (i_grn < DARK_TH) && (i_blu < DARK_TH);
  assign restart = i_valid && i_sof;

  assign in_h   = (h_pos >= H_LO)  && (h_pos < H_HI);
  assign in_l   = (h_pos >= L_LO)  && (h_pos < L_HI);
  assign in_r   = (h_pos >= R_LO)  && (h_pos < R_HI);
  assign in_v0  = (v_pos >= V0_LO) && (v_pos < V0_HI);
  assign in_v12 = (v_pos >= V0_HI) && (v_pos < V1_HI);
  assign in_v3  = (v_pos >= V1_HI) && (v_pos < V3_HI);
  assign in_v45 = (v_pos >= V3_HI) && (v_pos < V4_HI);
  assign in_v6  = (v_pos >= V4_HI) && (v_pos < V6_HI);

  // Per-segment hit for this pixel, then saturating next counts (sof restarts from zero).
  always_comb begin
    hit[0] = in_h && in_v0;
    hit[1] = in_l && in_v12;
    hit[2] = in_r && in_v12;
    hit[3] = in_h && in_v3;
    hit[4] = in_l && in_v45;
    hit[5] = in_r && in_v45;
    hit[6] = in_h && in_v6;
    hit    = hit & {7{i_valid && dark}};
    for (int k = 0; k < 7; k++) begin
      logic [11:0] base;
      base = restart ? 12'd0 : cnt[k];
      cnt_next[k] = (base == 12'hFFF) ? base : base + {11'd0, hit[k]};
      seg_hit[k]  = (cnt_next[k] >= MIN_HITS);
    end
  end

  // Frame control: open on sof, close on eof (both may land on the same pixel).
  always_comb begin
    state_next = state;
    count_en   = 1'b0;
    close      = 1'b0;
    case (state)
      IDLE: begin
        if (restart) begin
          count_en   = 1'b1;
          state_next = ACCUM;
          if (i_eof) begin
            close      = 1'b1;
            state_next = IDLE;
          end
        end
      end
      ACCUM: begin
        count_en = 1'b1;
        if (i_valid && i_eof) begin
          close      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Dark-pixel counters: cleared when a frame closes so the next frame starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) cnt[k] <= 12'd0;
    end else if (close) begin
      for (int k = 0; k < 7; k++) cnt[k] <= 12'd0;
    end else if (count_en) begin
      for (int k = 0; k < 7; k++) cnt[k] <= cnt_next[k];
    end
  end

  // First result stage: thresholded segment vector captured at frame close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= 7'd0;
      seg_v <= 1'b0;
    end else begin
      seg_v <= close;
      if (close) seg_r <= seg_hit;
    end
  end

  // Segment vector to digit; 77 is shared by 0 and D and resolves to 0.
  always_comb begin
    dec_digit = 4'h0;
    dec_match = 1'b1;
    case (seg_r)
      7'h77: dec_digit = 4'h0;
      7'h24: dec_digit = 4'h1;
      7'h5D: dec_digit = 4'h2;
      7'h6D: dec_digit = 4'h3;
      7'h2E: dec_digit = 4'h4;
      7'h6B: dec_digit = 4'h5;
      7'h7B: dec_digit = 4'h6;
      7'h27: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h3F: dec_digit = 4'hA;
      7'h7A: dec_digit = 4'hB;
      7'h53: dec_digit = 4'hC;
      7'h5B: dec_digit = 4'hE;
      7'h1B: dec_digit = 4'hF;
      default: begin
        dec_digit = 4'h0;
        dec_match = 1'b0;
      end
    endcase
  end

  // Output stage: result fields update with the one-cycle valid pulse and then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_seg   <= 7'd0;
      o_digit <= 4'h0;
      o_match <= 1'b0;
    end else begin
      o_valid <= seg_v;
      if (seg_v) begin
        o_seg   <= seg_r;
        o_digit <= dec_digit;
        o_match <= dec_match;
      end
    end
  end

  assign o_busy = (state == ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_disp_digit_seg_dec.sv
`default_nettype none
// ============================================================================
// Module  : tb_disp_digit_seg_dec
// Purpose : Self-checking bench for disp_digit_seg_dec with a geometric
//           reference model (rectangle table + per-frame dark counts).
// Revision: 1.0 - initial release
// ============================================================================
module tb_disp_digit_seg_dec;

  localparam int CW = 64;
  localparam int CH = 96;
  localparam int BB = 5;
  localparam int TT = 5;
  localparam int HT = (CH - 2 * BB - 3 * TT) / 2;
  localparam int DARK_LIMIT = 16;
  localparam int HITS = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_sof, i_eof;
  logic [6:0] cnt_h, cnt_v;
  logic [7:0] i_red, i_grn, i_blu;
  logic       o_valid;
  logic [6:0] o_seg;
  logic [3:0] o_digit;
  logic       o_match;
  logic       o_busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         rx0[7], rx1[7], ry0[7], ry1[7];
  logic [6:0] pat[16];
  int         mcnt[7];
  bit         m_open;
  logic [6:0] exp_seg;
  logic [3:0] exp_dig;
  logic       exp_match;

  disp_digit_seg_dec dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sof(i_sof), .i_eof(i_eof),
    .cnt_h(cnt_h), .cnt_v(cnt_v), .i_red(i_red), .i_grn(i_grn), .i_blu(i_blu),
    .o_valid(o_valid), .o_seg(o_seg), .o_digit(o_digit), .o_match(o_match),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic init_model();
    int hx0, hx1, lx0, lx1, qx0, qx1;
    hx0 = BB + TT;       hx1 = CW - BB - TT;
    lx0 = BB;            lx1 = BB + TT;
    qx0 = CW - BB - TT;  qx1 = CW - BB;
    rx0 = '{hx0, lx0, qx0, hx0, lx0, qx0, hx0};
    rx1 = '{hx1, lx1, qx1, hx1, lx1, qx1, hx1};
    ry0 = '{BB, BB + TT, BB + TT, BB + TT + HT, BB + 2*TT + HT, BB + 2*TT + HT, BB + 2*TT + 2*HT};
    ry1 = '{BB + TT, BB + TT + HT, BB + TT + HT, BB + 2*TT + HT, BB + 2*TT + 2*HT, BB + 2*TT + 2*HT, BB + 3*TT + 2*HT};
    pat = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E, 7'h6B, 7'h7B, 7'h27,
            7'h7F, 7'h6F, 7'h3F, 7'h7A, 7'h53, 7'h77, 7'h5B, 7'h1B};
    m_open = 0;
    for (int j = 0; j < 7; j++) mcnt[j] = 0;
  endtask

  function automatic int seg_at(input int h, input int v);
    for (int k = 0; k < 7; k++)
      if (h >= rx0[k] && h < rx1[k] && v >= ry0[k] && v < ry1[k]) return k;
    return -1;
  endfunction

  task automatic model_decode();
    exp_dig = 4'h0;
    exp_match = 1'b0;
    for (int d = 15; d >= 0; d--)
      if (pat[d] == exp_seg) begin
        exp_dig = 4'(d);
        exp_match = 1'b1;
      end
  endtask

  task automatic dark_px(output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    r = 8'($urandom_range(0, 15));
    g = 8'($urandom_range(0, 15));
    b = 8'($urandom_range(0, 15));
  endtask

  task automatic light_px(output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    logic [7:0] hi;
    r  = 8'($urandom_range(0, 255));
    g  = 8'($urandom_range(0, 255));
    b  = 8'($urandom_range(0, 255));
    hi = 8'($urandom_range(16, 255));
    case ($urandom_range(0, 2))
      0: r = hi;
      1: g = hi;
      default: b = hi;
    endcase
  endtask

  // Drive one qualified pixel for one clock and advance the reference model.
  task automatic pix(input bit s, input bit e, input int h, input int v,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int k;
    i_valid = 1'b1; i_sof = s; i_eof = e;
    cnt_h = 7'(h); cnt_v = 7'(v);
    i_red = r; i_grn = g; i_blu = b;
    if (s) begin
      m_open = 1;
      for (int j = 0; j < 7; j++) mcnt[j] = 0;
    end
    if (m_open) begin
      k = seg_at(h, v);
      if (k >= 0 && int'(r) < DARK_LIMIT && int'(g) < DARK_LIMIT && int'(b) < DARK_LIMIT && mcnt[k] < 4095)
        mcnt[k]++;
      if (e) begin
        m_open = 0;
        for (int j = 0; j < 7; j++) exp_seg[j] = (mcnt[j] >= HITS);
        model_decode();
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
  endtask

  // Render a digit pattern; drives every pixel except the final (63,95) eof pixel.
  task automatic stream_digit(input logic [6:0] p, input bit full);
    logic [7:0] r, g, b;
    int k;
    if (full) begin
      for (int v = 0; v < CH; v++)
        for (int h = 0; h < CW; h++) begin
          if (!(h == CW - 1 && v == CH - 1)) begin
            k = seg_at(h, v);
            if (k >= 0 && p[k]) dark_px(r, g, b); else light_px(r, g, b);
            pix(h == 0 && v == 0, 1'b0, h, v, r, g, b);
          end
        end
    end else begin
      light_px(r, g, b);
      pix(1'b1, 1'b0, 0, 0, r, g, b);
      for (int s = 0; s < 7; s++)
        for (int v = ry0[s]; v < ry1[s]; v++)
          for (int h = rx0[s]; h < rx1[s]; h++) begin
            if (p[s]) dark_px(r, g, b); else light_px(r, g, b);
            pix(1'b0, 1'b0, h, v, r, g, b);
          end
    end
  endtask

  task automatic eof_px();
    logic [7:0] r, g, b;
    light_px(r, g, b);
    pix(1'b0, 1'b1, CW - 1, CH - 1, r, g, b);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 0; i_sof = 0; i_eof = 0;
    cnt_h = 0; cnt_v = 0; i_red = 0; i_grn = 0; i_blu = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_seg, o_digit, o_match, o_busy} !== 14'd0)
      $display("FAIL reset_outputs: got v=%b seg=%h dig=%h m=%b busy=%b, want all 0",
               o_valid, o_seg, o_digit, o_match, o_busy);
    if ({o_valid, o_seg, o_digit, o_match, o_busy} !== 14'd0) errors++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_digit8();
    stream_digit(pat[8], 1'b1);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL d8_busy: got %b want 1", o_busy);
    end
    eof_px();
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL d8_n1: busy=%b valid=%b, want 0 0", o_busy, o_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_seg !== 7'h7F || o_digit !== 4'h8 || o_match !== 1'b1 || o_seg !== exp_seg) begin
      errors++;
      $display("FAIL d8_result: v=%b seg=%h dig=%h m=%b, want 1 7f 8 1 (model seg %h)",
               o_valid, o_seg, o_digit, o_match, exp_seg);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_seg !== 7'h7F || o_digit !== 4'h8) begin
      errors++;
      $display("FAIL d8_hold: v=%b seg=%h dig=%h, want 0 7f 8", o_valid, o_seg, o_digit);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] want;
    for (int d = 0; d < 16; d++) begin
      stream_digit(pat[d], 1'b0);
      eof_px();
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_early d=%0d: valid=%b want 0", d, o_valid);
      end
      @(posedge clk); #1;
      want = (d == 13) ? 4'h0 : 4'(d);
      checks++;
      if (o_valid !== 1'b1 || o_seg !== pat[d] || o_digit !== want || o_match !== 1'b1 ||
          o_seg !== exp_seg || o_digit !== exp_dig) begin
        errors++;
        $display("FAIL sweep d=%0d: v=%b seg=%h dig=%h m=%b, want 1 %h %h 1",
                 d, o_valid, o_seg, o_digit, o_match, pat[d], want);
      end
    end
  endtask

  task automatic test_threshold();
    logic [7:0] r, g, b;
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      n = 127 + pass;
      light_px(r, g, b);
      pix(1'b1, 1'b0, 0, 0, r, g, b);
      for (int i = 0; i < n; i++)
        pix(1'b0, 1'b0, rx0[0] + i % 44, ry0[0] + i / 44, 8'h0F, 8'h0F, 8'h0F);
      pix(1'b0, 1'b0, rx0[0] + n % 44, ry0[0] + n / 44, 8'h10, 8'h10, 8'h10);
      for (int i = n + 1; i < n + 40; i++) begin
        dark_px(r, g, b);
        case ($urandom_range(0, 2))
          0: r = 8'h10;
          1: g = 8'h10;
          default: b = 8'h10;
        endcase
        pix(1'b0, 1'b0, rx0[0] + i % 44, ry0[0] + i / 44, r, g, b);
      end
      eof_px();
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_seg[0] !== pass[0] || o_seg !== exp_seg) begin
        errors++;
        $display("FAIL threshold n=%0d: v=%b seg=%h, want 1 seg[0]=%0d (model %h)",
                 n, o_valid, o_seg, pass, exp_seg);
      end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] r, g, b;
    stream_digit(7'h08, 1'b0);
    eof_px();
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_seg !== 7'h08 || o_match !== 1'b0 || o_digit !== 4'h0 || exp_match !== 1'b0) begin
      errors++;
      $display("FAIL invalid_pattern: v=%b seg=%h dig=%h m=%b, want 1 08 0 0",
               o_valid, o_seg, o_digit, o_match);
    end
    @(posedge clk); #1;
    dark_px(r, g, b);
    pix(1'b0, 1'b1, 20, 7, r, g, b);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_eof cycle %0d: valid=%b busy=%b, want 0 0", i, o_valid, o_busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    logic [7:0] r, g, b;
    int lens[2];
    lens = '{5000, 4196};
    for (int t = 0; t < 2; t++) begin
      light_px(r, g, b);
      pix(1'b1, 1'b0, 0, 0, r, g, b);
      for (int i = 0; i < lens[t]; i++) begin
        dark_px(r, g, b);
        pix(1'b0, 1'b0, 10, 6, r, g, b);
      end
      eof_px();
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_seg !== 7'h01 || o_seg !== exp_seg) begin
        errors++;
        $display("FAIL saturation len=%0d: v=%b seg=%h, want 1 01", lens[t], o_valid, o_seg);
      end
    end
    // Mid-frame sof: segments 1 and 4 painted before the restart must vanish.
    light_px(r, g, b);
    pix(1'b1, 1'b0, 0, 0, r, g, b);
    for (int s = 1; s < 5; s += 3)
      for (int v = ry0[s]; v < ry1[s]; v++)
        for (int h = rx0[s]; h < rx1[s]; h++) begin
          dark_px(r, g, b);
          pix(1'b0, 1'b0, h, v, r, g, b);
        end
    light_px(r, g, b);
    pix(1'b1, 1'b0, 0, 0, r, g, b);
    for (int v = ry0[6]; v < ry1[6]; v++)
      for (int h = rx0[6]; h < rx1[6]; h++) begin
        dark_px(r, g, b);
        pix(1'b0, 1'b0, h, v, r, g, b);
      end
    eof_px();
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_seg !== 7'h40 || o_match !== 1'b0 || o_seg !== exp_seg) begin
      errors++;
      $display("FAIL mid_sof: v=%b seg=%h m=%b, want 1 40 0", o_valid, o_seg, o_match);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r, g, b;
    light_px(r, g, b);
    pix(1'b1, 1'b0, 0, 0, r, g, b);
    for (int i = 0; i < 30; i++) begin
      dark_px(r, g, b);
      pix(1'b0, 1'b0, 10 + i, 6, r, g, b);
    end
    rst = 1'b1;
    m_open = 0;
    #1;
    checks++;
    if ({o_valid, o_seg, o_digit, o_match, o_busy} !== 14'd0) begin
      errors++;
      $display("FAIL midframe_reset: v=%b seg=%h dig=%h m=%b busy=%b, want all 0",
               o_valid, o_seg, o_digit, o_match, o_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    eof_px();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b0 || o_seg !== 7'h00) begin
        errors++;
        $display("FAIL post_reset_eof cycle %0d: valid=%b seg=%h, want 0 00", i, o_valid, o_seg);
      end
      @(posedge clk); #1;
    end
    dark_px(r, g, b);
    pix(1'b1, 1'b1, 10, 6, r, g, b);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n1: busy=%b valid=%b, want 0 0", o_busy, o_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_seg !== 7'h00 || o_match !== 1'b0 || o_digit !== 4'h0 || o_seg !== exp_seg) begin
      errors++;
      $display("FAIL single_frame: v=%b seg=%h dig=%h m=%b, want 1 00 0 0",
               o_valid, o_seg, o_digit, o_match);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, g, b;
    logic [11:0] prev, cur;
    int d;
    d = $urandom_range(0, 15);
    stream_digit(pat[d], 1'b0);
    eof_px();
    prev = {exp_seg, exp_dig, exp_match};
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 1) == 1) dark_px(r, g, b); else light_px(r, g, b);
      pix(1'b1, 1'b1, $urandom_range(0, CW - 1), $urandom_range(0, CH - 1), r, g, b);
      cur = {exp_seg, exp_dig, exp_match};
      checks++;
      if (o_valid !== 1'b1 || {o_seg, o_digit, o_match} !== prev) begin
        errors++;
        $display("FAIL b2b step %0d: v=%b got %h, want 1 %h", i, o_valid, {o_seg, o_digit, o_match}, prev);
      end
      prev = cur;
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || {o_seg, o_digit, o_match} !== prev) begin
      errors++;
      $display("FAIL b2b last: v=%b got %h, want 1 %h", o_valid, {o_seg, o_digit, o_match}, prev);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b pulse_end: valid=%b want 0", o_valid);
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_digit8();
    test_sweep();
    test_threshold();
    test_invalid();
    test_saturation();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_digit_seg_dec.md
Name: disp_digit_seg_dec

Overview:
- Recovers a hex digit from a rendered 7-segment digit cell in a DVI pixel stream.
- It is the inverse of our 7-segment digit renderer. Segments are drawn dark on a coloured background, in a MAX_H x MAX_V cell.
- Per frame, it counts dark pixels inside each segment window and thresholds each count into a segment vector.
- It maps that vector back to 0..F with a match flag. It sits on the video loopback/self-check path after the pixel pipeline.

Parameters:
- MAX_H, 7'd64, cell width in pixels.
- MAX_V, 7'd96, cell height in pixels.
- BOUNDARY, 7'd5, margin between the cell edge and the segments.
- THICKNESS, 7'd5, segment stroke width.
- DARK_TH, 8'h10, a pixel is dark when red, grn and blu are all < DARK_TH.
- MIN_HITS, 12'd128, dark-pixel count at or above which a segment is judged lit.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-high reset.
- i_valid, input, 1, pixel qualifier.
- i_sof, input, 1, first pixel of the cell frame; ignored unless i_valid.
- i_eof, input, 1, last pixel of the cell frame; ignored unless i_valid.
- cnt_h, input, 7, horizontal position within the cell.
- cnt_v, input, 7, vertical position within the cell.
- i_red, input, 8, pixel red.
- i_grn, input, 8, pixel green.
- i_blu, input, 8, pixel blue.
- o_valid, output, 1, one-cycle pulse; result fields are valid.
- o_seg, output, 7, decided segment vector: [0] top, [1] upper-left, [2] upper-right, [3] middle, [4] lower-left, [5] lower-right, [6] bottom.
- o_digit, output, 4, decoded digit.
- o_match, output, 1, o_seg equals a legal digit pattern.
- o_busy, output, 1, a frame is open (ACCUM state).

Behaviour:
- Reset: rst asserted clears all state asynchronously, at any time including mid-frame. State goes to IDLE, counters to 0, and every output to 0. Any partial frame is discarded.
- Segment windows: HEIGHT=(MAX_V-2*BOUNDARY-3*THICKNESS)/2, which is 35 with defaults. All ranges are lower-inclusive, upper-exclusive.
  - H-span (segs 0, 3, 6): h in [B+T, MAX_H-B-T).
  - Left-span (segs 1, 4): h in [B, B+T).
  - Right-span (segs 2, 5): h in [MAX_H-B-T, MAX_H-B).
  - seg0: v in [B, B+T).
  - seg1 and seg2: v in [B+T, B+T+HEIGHT).
  - seg3: v in [B+T+HEIGHT, B+2T+HEIGHT).
  - seg4 and seg5: v in [B+2T+HEIGHT, B+2T+2*HEIGHT).
  - seg6: v in [B+2T+2*HEIGHT, B+3T+2*HEIGHT).
  - Windows are disjoint. Dark pixels outside all windows are ignored.
- Counters: seven 12-bit dark-pixel counters, one per segment. Each saturates at 4095 and never wraps.
- States:
  - IDLE: no frame open. Pixels are not counted. i_eof is ignored and produces no o_valid. A valid i_sof moves to ACCUM.
  - ACCUM: qualified pixels are counted. A valid i_sof restarts the frame: counters are loaded with that pixel's contribution only, and the state stays ACCUM. A valid i_eof closes the frame and moves to IDLE.
- Frame open (IDLE to ACCUM, cycle S): counters load the sof pixel's contribution.
- Frame close (eof pixel, cycle N):
  - The eof pixel is counted.
  - seg_r[k] <= (cnt_next[k] >= MIN_HITS), using the counter values that include the eof pixel.
  - Counters clear.
- i_sof and i_eof on the same valid pixel: a one-pixel frame. It is counted and closed in that cycle; the state ends in IDLE.
- Pipeline:
  - N+1: seg_r is registered.
  - N+2: o_valid=1, with o_seg, o_digit and o_match registered from seg_r.
  - o_seg, o_digit and o_match hold until the next result. o_valid is high for exactly one cycle.
  - A new sof is accepted from cycle N+1, and overlapping results do not interfere.
  - The minimum spacing between results is 1 cycle, for back-to-back single-pixel frames.
- Pattern table, hex of {s6..s0}:
  - 0=77, 1=24, 2=5D, 3=6D, 4=2E, 5=6B, 6=7B, 7=27.
  - 8=7F, 9=6F, A=3F, B=7A, C=53, E=5B, F=1B.
  - D shares 77 with 0: 77 decodes to 4'h0, so D is never reported.
  - Any other vector gives o_match=0 and o_digit=4'h0. o_seg still reports the raw vector.
- o_busy=1 exactly while the state is ACCUM.

Test Plan:
- Render digit 8 with defaults: background FF/FF/FF, segments 00/00/00, full 64x96 raster, sof at (0,0), eof at (63,95). Required: o_valid two cycles after eof, o_seg=7F, o_digit=8, o_match=1, and o_busy low from N+1.
- Sweep digits 0..F, each rendered as above. Required: digits 0..C, E and F decode to themselves with o_match=1. Digit D gives o_seg=77, o_digit=0, o_match=1.
- Threshold edge: seg0 window with exactly 127 dark pixels, then a repeat with exactly 128. Required: o_seg[0]=0, then 1. A pixel at 10/10/10 is never dark; a pixel at 0F/0F/0F is always dark.
- Invalid pattern (only seg3 dark) -> o_seg=08, o_match=0, o_digit=0. An eof in IDLE without a prior sof -> no o_valid.
- Saturation: hold a dark pixel at (10,6) for 5000 valid cycles, then eof. Required: no wrap, and seg0 reports lit. A mid-frame sof discards earlier counts.
- Assert rst for one cycle mid-frame, then issue eof. Required: all outputs 0 immediately, no o_valid. A following sof/sof+eof single dark pixel frame gives o_valid with o_seg=00 (when MIN_HITS>1).
